// File: rtl/readout_rx_bin_controller_pkg.sv
// Shared types for the readout RX bin controller: FSM state encodings.
package readout_rx_bin_controller_pkg;

    localparam int unsigned RX_BIN_CTRL_STATE_WIDTH = 3;

    typedef enum logic [RX_BIN_CTRL_STATE_WIDTH-1:0] {
        RX_BIN_CTRL_IDLE   = 3'd0,
        RX_BIN_CTRL_START  = 3'd1,
        RX_BIN_CTRL_ACCUM  = 3'd2,
        RX_BIN_CTRL_SETTLE = 3'd3,
        RX_BIN_CTRL_RESULT = 3'd4
    } rx_bin_ctrl_state_e;

endpackage

// File: rtl/readout_rx_sample_counter.sv
// Window sample counter: latches the window length, counts forwarded samples,
// and flags when the current sample is the last one of the window.
module readout_rx_sample_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] len_in,
    input  logic             clear,
    input  logic             inc,
    output logic             last_c
);

    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q   <= '0;
            count_q <= '0;
        end else begin
            if (load) begin
                len_q <= len_in;
            end
            if (clear) begin
                count_q <= '0;
            end else if (inc) begin
                count_q <= count_q + WIDTH'(1);
            end
        end
    end

    // len is never 0 when counting, so len-1 cannot wrap
    assign last_c = (count_q == (len_q - WIDTH'(1)));

endmodule

// File: rtl/readout_rx_bin_controller.sv
// Sequences one readout RX bin accumulator over a measurement window and
// hands the final bin count and state decision back to the scheduler.
module readout_rx_bin_controller
    import readout_rx_bin_controller_pkg::*;
#(
    parameter int unsigned BIN_COUNTER_WIDTH  = 16,
    parameter int unsigned SAMPLE_COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_COUNT_WIDTH-1:0] cfg_num_samples,
    input  logic                          meas_req,
    output logic                          meas_ack,
    output logic                          cfg_err,
    input  logic                          abort,
    input  logic                          sample_valid,
    output logic                          acc_start_count,
    output logic                          acc_valid_in,
    input  logic [BIN_COUNTER_WIDTH-1:0]  acc_bin_count,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [BIN_COUNTER_WIDTH-1:0]  result_count,
    output logic                          result_state,
    output logic                          busy,
    output logic                          sample_drop
);

    localparam int unsigned BCW = BIN_COUNTER_WIDTH;
    localparam int unsigned SCW = SAMPLE_COUNT_WIDTH;

    rx_bin_ctrl_state_e state_q;
    rx_bin_ctrl_state_e state_d;

    logic cfg_legal_c;
    logic accept_c;
    logic drop_state_c;
    logic count_clear_c;
    logic count_inc_c;
    logic sample_last_c;
    logic result_load_c;

    // Window length below the accumulator midpoint keeps the up/down count from wrapping
    assign cfg_legal_c = (cfg_num_samples != '0) && ((cfg_num_samples >> (BCW - 1)) == '0);

    readout_rx_sample_counter #(
        .WIDTH (SCW)
    ) u_sample_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept_c),
        .len_in (cfg_num_samples),
        .clear  (count_clear_c),
        .inc    (count_inc_c),
        .last_c (sample_last_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_BIN_CTRL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept_c      = 1'b0;
        cfg_err       = 1'b0;
        acc_valid_in  = 1'b0;
        count_clear_c = 1'b0;
        count_inc_c   = 1'b0;
        drop_state_c  = 1'b0;
        result_load_c = 1'b0;
        unique case (state_q)
            RX_BIN_CTRL_IDLE: begin
                drop_state_c = 1'b1;
                if (meas_req) begin
                    if (cfg_legal_c) begin
                        accept_c = 1'b1;
                        state_d  = RX_BIN_CTRL_START;
                    end else begin
                        cfg_err = rst;
                    end
                end
            end
            RX_BIN_CTRL_START: begin
                drop_state_c  = 1'b1;
                count_clear_c = 1'b1;
                state_d       = abort ? RX_BIN_CTRL_IDLE : RX_BIN_CTRL_ACCUM;
            end
            RX_BIN_CTRL_ACCUM: begin
                // abort wins over a coincident sample, which is then not forwarded
                if (abort) begin
                    state_d = RX_BIN_CTRL_IDLE;
                end else begin
                    acc_valid_in = sample_valid;
                    count_inc_c  = sample_valid;
                    if (sample_valid && sample_last_c) begin
                        state_d = RX_BIN_CTRL_SETTLE;
                    end
                end
            end
            RX_BIN_CTRL_SETTLE: begin
                drop_state_c = 1'b1;
                if (abort) begin
                    state_d = RX_BIN_CTRL_IDLE;
                end else begin
                    result_load_c = 1'b1;
                    state_d       = RX_BIN_CTRL_RESULT;
                end
            end
            RX_BIN_CTRL_RESULT: begin
                drop_state_c = 1'b1;
                if (result_ready) begin
                    state_d = RX_BIN_CTRL_IDLE;
                end
            end
            default: begin
                state_d = RX_BIN_CTRL_IDLE;
            end
        endcase
    end

    // Registered status outputs track the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meas_ack        <= 1'b0;
            acc_start_count <= 1'b0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            sample_drop     <= 1'b0;
            result_count    <= '0;
            result_state    <= 1'b0;
        end else begin
            meas_ack        <= accept_c;
            acc_start_count <= (state_d == RX_BIN_CTRL_START);
            busy            <= (state_d != RX_BIN_CTRL_IDLE);
            result_valid    <= (state_d == RX_BIN_CTRL_RESULT);
            sample_drop     <= sample_valid && drop_state_c;
            if (result_load_c) begin
                result_count <= acc_bin_count;
                result_state <= acc_bin_count[BCW-1];
            end
        end
    end

endmodule
